// File: rtl/syn_update_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : syn_update_sequencer                                          |
// | Description : Sweeps one pre-neuron row of the synaptic SRAM with           |
// |               read-wait-write cycles so the core can write back updated     |
// |               weights. Optional macro SYN_UPD_SKIP_ZERO_EN skips rows whose  |
// |               pre spike count is zero.                                      |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module syn_update_sequencer #(
   parameter int INPUT_NEURON         = 784,
   parameter int OUTPUT_NEURON        = 256,
   parameter int POST_NEUR_PARALLEL   = 4,
   parameter int PRE_NEUR_ADDR_WIDTH  = 10,
   parameter int POST_NEUR_ADDR_WIDTH = 10,
   parameter int PRE_NEUR_DATA_WIDTH  = 8,
   parameter int SYN_ARRAY_ADDR_WIDTH = 16
) (
   input  logic                            CLK,
   input  logic                            RST_N,
   input  logic                            START,
   input  logic [PRE_NEUR_ADDR_WIDTH-1:0]  PRE_ADDR,
   input  logic [PRE_NEUR_DATA_WIDTH-1:0]  PRE_S_CNT,
   input  logic                            HALT,
   output logic                            BUSY,
   output logic                            DONE,
   output logic                            CTRL_SYNARRAY_CS,
   output logic                            CTRL_SYNARRAY_WE,
   output logic [SYN_ARRAY_ADDR_WIDTH-1:0] CTRL_SYNARRAY_ADDR,
   output logic [POST_NEUR_ADDR_WIDTH-1:0] CTRL_POST_NEURON_ADDRESS
);

   localparam int WORDS_PER_ROW = OUTPUT_NEURON / POST_NEUR_PARALLEL;
   localparam int IDX_W         = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_ROW - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_WAIT = 3'd2,
      S_WR   = 3'd3,
      S_FIN  = 3'd4
   } state_t;

   state_t                            state_q, state_d;
   logic [IDX_W-1:0]                  idx_q, idx_d;
   logic [PRE_NEUR_ADDR_WIDTH-1:0]    pre_addr_q, pre_addr_d;
   logic [PRE_NEUR_DATA_WIDTH-1:0]    pre_s_cnt_q, pre_s_cnt_d;
   logic                              skip_q, skip_d;
   logic                              busy_q, busy_d;
   logic                              done_q, done_d;
   logic                              cs_q, cs_d;
   logic                              we_q, we_d;
   logic [SYN_ARRAY_ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [POST_NEUR_ADDR_WIDTH-1:0]   post_addr_q, post_addr_d;

   logic [31:0] base_full;
   logic [31:0] word_addr_full;
   logic [31:0] post_full;
   logic        start_ok;
   logic        skip_sweep;

   assign start_ok = $unsigned(32'(PRE_ADDR)) < $unsigned(32'(INPUT_NEURON));

`ifdef SYN_UPD_SKIP_ZERO_EN
   assign skip_sweep = (PRE_S_CNT == '0);
`else
   logic unused_pre_s_cnt;
   assign skip_sweep       = 1'b0;
   assign unused_pre_s_cnt = ^pre_s_cnt_q;
`endif

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      pre_addr_d  = pre_addr_q;
      pre_s_cnt_d = pre_s_cnt_q;
      skip_d      = skip_q;
      busy_d      = (state_q != S_IDLE);
      done_d      = 1'b0;
      cs_d        = 1'b0;
      we_d        = 1'b0;
      addr_d      = addr_q;
      post_addr_d = post_addr_q;

      base_full      = 32'(pre_addr_q) * 32'(WORDS_PER_ROW);
      word_addr_full = base_full + 32'(idx_q);
      post_full      = 32'(idx_q) * 32'(POST_NEUR_PARALLEL);

      unique case (state_q)
         S_IDLE: begin
            if (START) begin
               pre_addr_d  = PRE_ADDR;
               pre_s_cnt_d = PRE_S_CNT;
               idx_d       = '0;
               if (start_ok && !skip_sweep) begin
                  state_d = S_RD;
               end else begin
                  // Rejected rows spend one silent FIN cycle so DONE lands two cycles after START.
                  skip_d  = 1'b1;
                  state_d = S_FIN;
               end
            end
         end
         S_RD: begin
            if (!HALT) begin
               cs_d        = 1'b1;
               addr_d      = SYN_ARRAY_ADDR_WIDTH'(word_addr_full);
               post_addr_d = POST_NEUR_ADDR_WIDTH'(post_full);
               state_d     = S_WAIT;
            end
         end
         S_WAIT: begin
            state_d = S_WR;
         end
         S_WR: begin
            cs_d = 1'b1;
            we_d = 1'b1;
            if (idx_q == LAST_IDX) begin
               state_d = S_FIN;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = S_RD;
            end
         end
         S_FIN: begin
            if (skip_q) begin
               skip_d = 1'b0;
            end else begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         pre_addr_q  <= '0;
         pre_s_cnt_q <= '0;
         skip_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cs_q        <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         post_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         pre_addr_q  <= pre_addr_d;
         pre_s_cnt_q <= pre_s_cnt_d;
         skip_q      <= skip_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         cs_q        <= cs_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         post_addr_q <= post_addr_d;
      end
   end

   assign BUSY                     = busy_q;
   assign DONE                     = done_q;
   assign CTRL_SYNARRAY_CS         = cs_q;
   assign CTRL_SYNARRAY_WE         = we_q;
   assign CTRL_SYNARRAY_ADDR       = addr_q;
   assign CTRL_POST_NEURON_ADDRESS = post_addr_q;

endmodule
`default_nettype wire

// File: doc/syn_update_sequencer.md
Name: syn_update_sequencer

Overview:
- Initiator side of the synaptic-array port: generates CS/WE/ADDR sequences that drive the synaptic core and its SRAM.
- On a START request for one pre-synaptic neuron, sweeps every weight word of that neuron's row with read-wait-write cycles, so the core's ffstdp_update lanes write back updated weights.
- Also drives the post-neuron address so post spike counts arrive aligned with each weight word.
- Sits between the top-level training controller and synaptic_core.

Parameters:
- INPUT_NEURON, 784, number of pre-synaptic neurons (rows).
- OUTPUT_NEURON, 256, number of post-synaptic neurons.
- POST_NEUR_PARALLEL, 4, weights per SRAM word; OUTPUT_NEURON must be a multiple of it.
- PRE_NEUR_ADDR_WIDTH, 10, width of the pre-neuron index.
- POST_NEUR_ADDR_WIDTH, 10, width of the post-neuron address.
- PRE_NEUR_DATA_WIDTH, 8, width of the pre spike count.
- SYN_ARRAY_ADDR_WIDTH, 16, width of the SRAM word address.
- Derived: WORDS_PER_ROW = OUTPUT_NEURON/POST_NEUR_PARALLEL (64 at defaults).

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST_N  in  1  synchronous, active-low reset.
- START  in  1  one-cycle request; sampled only in IDLE.
- PRE_ADDR  in  PRE_NEUR_ADDR_WIDTH  pre-neuron row index; latched on an accepted START.
- PRE_S_CNT  in  PRE_NEUR_DATA_WIDTH  pre spike count; latched on an accepted START.
- HALT  in  1  pauses the sweep before the next read is issued.
- BUSY  out  1  sweep in progress.
- DONE  out  1  one-cycle pulse when the sweep completes.
- CTRL_SYNARRAY_CS  out  1  SRAM chip select.
- CTRL_SYNARRAY_WE  out  1  SRAM write enable.
- CTRL_SYNARRAY_ADDR  out  SYN_ARRAY_ADDR_WIDTH  SRAM word address.
- CTRL_POST_NEURON_ADDRESS  out  POST_NEUR_ADDR_WIDTH  first post neuron of the current word.

Behaviour:
- All outputs are registered.
- Reset (RST_N=0 at a clock edge):
  - State goes to IDLE; word index is cleared to 0.
  - All outputs go to 0.
  - Reset during a sweep aborts it immediately, with no DONE. A word already read but not yet written stays unmodified.
- States: IDLE, RD, WAIT, WR, FIN.
- IDLE:
  - START=1 with PRE_ADDR < INPUT_NEURON: latch PRE_ADDR and PRE_S_CNT, clear word index idx, go to RD. BUSY=1 from the next cycle.
  - START=1 with PRE_ADDR >= INPUT_NEURON: no SRAM access; go to FIN.
- RD:
  - HALT=1: CS=0 and the state holds.
  - HALT=0: CS=1, WE=0, ADDR = base + idx, POST_NEURON_ADDRESS = idx*POST_NEUR_PARALLEL; then go to WAIT.
  - base = PRE_ADDR*WORDS_PER_ROW, truncated to SYN_ARRAY_ADDR_WIDTH.
- WAIT:
  - CS=0; ADDR and POST_NEURON_ADDRESS are held.
  - Covers the 1-cycle SRAM read latency so the core's combinational update settles. Go to WR.
- WR:
  - CS=1, WE=1, same ADDR.
  - If idx = WORDS_PER_ROW-1, go to FIN; else idx+1 and go to RD.
- FIN:
  - DONE=1 for exactly one cycle, CS=WE=0; go to IDLE.
  - BUSY is high through the FIN cycle and low the cycle after.
- HALT is honoured only in RD. WAIT and WR never stall, so no read-write pair is ever split.
- START while BUSY=1 is ignored; nothing is queued.
- Cycle counts at defaults (START sampled at cycle 0):
  - First read at cycle 1, first write at cycle 3.
  - Last write at cycle 192, DONE at cycle 193.
  - 3*WORDS_PER_ROW+1 cycles from START to DONE with no HALT.
- WE=1 never occurs without CS=1.
- ADDR is never incremented between the RD and WR of one word.

Optional Feature:
- Macro: SYN_UPD_SKIP_ZERO_EN.
- Defined: an accepted START with latched PRE_S_CNT=0 skips the sweep and goes directly to FIN. No SRAM access; DONE comes the cycle after START+1 (2 cycles after START).
- Undefined: PRE_S_CNT is ignored and every accepted START performs the full sweep.

Test Plan:
- Reset, then START with PRE_ADDR=0 and PRE_S_CNT=5:
  - Required: addresses 0..63, each as a RD, a CS=0 cycle, then a WR.
  - Required: POST_NEURON_ADDRESS steps 0,4,...,252; DONE at cycle 193; BUSY low at 194.
- START with PRE_ADDR=783: first ADDR=50112, last ADDR=50175; no WE without CS; exactly 64 writes.
- HALT=1 for 10 cycles while in RD at idx=7:
  - Required: CS stays 0 throughout; read of word 7 issues after HALT falls.
  - Required: DONE delayed by exactly 10 cycles.
  - HALT asserted during WAIT has no effect.
- START re-pulsed at cycles 50 and 193, and PRE_ADDR=784:
  - Required: both re-pulses ignored.
  - Required: PRE_ADDR=784 gives no CS, with DONE 2 cycles after START.
- RST_N=0 at cycle 100 of a sweep: all outputs 0 next cycle; no DONE. A new START then runs a full sweep from idx 0.
- PRE_S_CNT=0:
  - With SYN_UPD_SKIP_ZERO_EN: no CS; DONE 2 cycles after START.
  - Without the macro: full 64-word sweep.
